output_burst_buffer: RTL and testbench

OUTPUT_BURST_BUFFER -- requirements
Module: output_burst_buffer

---
 rtl/output_burst_buffer.sv | 182 ++++++++++++++++++
 tb/tb_output_burst_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_burst_buffer.sv
// Output burst buffer: addressed result store that can return one entry
// (non-destructive read) or drain every valid entry in ascending address
// order as a valid/ready burst (destructive read).
module output_burst_buffer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              burst_req,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              rd_miss,
   output logic [ADDR_W:0]   valid_count
);

   typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_e;

   state_e            state_q, state_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  mask_q, mask_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              rd_miss_q, rd_miss_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic              load;
   logic              hs;
   logic [DEPTH-1:0]  rest;
   logic [ADDR_W-1:0] lo_valid, hi_valid, lo_rest, hi_rest;
   logic [ADDR_W:0]   count;

   function automatic logic [ADDR_W-1:0] lowest(input logic [DEPTH-1:0] v);
      logic [ADDR_W-1:0] r;
      r = '0;
      for (int unsigned i = DEPTH; i > 0; i--) begin
         if (v[i-1]) r = ADDR_W'(i - 1);
      end
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] highest(input logic [DEPTH-1:0] v);
      logic [ADDR_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (v[i]) r = ADDR_W'(i);
      end
      return r;
   endfunction

   assign hs       = out_valid_q & out_ready;
   assign lo_valid = lowest(valid_q);
   assign hi_valid = highest(valid_q);
   assign lo_rest  = lowest(rest);
   assign hi_rest  = highest(rest);

   // Burst mask with the currently presented entry removed
   always_comb begin
      rest        = mask_q;
      rest[cur_q] = 1'b0;
   end

   // Popcount of the registered valid vector
   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         count = count + {{ADDR_W{1'b0}}, valid_q[i]};
      end
   end

   // Storage array; written in every state, never reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Next-state, valid/mask bookkeeping and output word selection
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      mask_d      = mask_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      cur_d       = cur_q;
      rd_miss_d   = 1'b0;
      load        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rd_req) begin
               if (valid_q[rd_addr]) begin
                  load        = 1'b1;
                  cur_d       = rd_addr;
                  out_valid_d = 1'b1;
                  out_last_d  = 1'b1;
                  state_d     = SINGLE;
               end else begin
                  rd_miss_d = 1'b1;
               end
            end else if (burst_req) begin
               if (valid_q == '0) begin
                  rd_miss_d = 1'b1;
               end else begin
                  mask_d      = valid_q;
                  load        = 1'b1;
                  cur_d       = lo_valid;
                  out_valid_d = 1'b1;
                  out_last_d  = (lo_valid == hi_valid);
                  state_d     = BURST;
               end
            end
         end
         SINGLE: begin
            if (hs) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               state_d     = IDLE;
            end
         end
         BURST: begin
            if (hs) begin
               valid_d[cur_q] = 1'b0;
               mask_d         = rest;
               if (rest == '0) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = IDLE;
               end else begin
                  load       = 1'b1;
                  cur_d      = lo_rest;
                  out_last_d = (lo_rest == hi_rest);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A write lands after the handshake clear so it wins on a same-address collision
      if (wr_en) valid_d[wr_addr] = 1'b1;
      // Forward a same-edge write so a freshly loaded word is never stale
      if (load) out_data_d = (wr_en && (wr_addr == cur_d)) ? wr_data : mem[cur_d];
   end

   // State and output registers with asynchronous abort on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         mask_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         rd_miss_q   <= 1'b0;
         cur_q       <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         mask_q      <= mask_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         rd_miss_q   <= rd_miss_d;
         cur_q       <= cur_d;
      end
   end

   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign rd_miss     = rd_miss_q;
   assign busy        = (state_q != IDLE);
   assign valid_count = count;

endmodule

// File: tb/tb_output_burst_buffer.sv
// Directed scoreboard bench for output_burst_buffer.
module tb_output_burst_buffer;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              burst_req;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              rd_miss;
   logic [ADDR_W:0]   valid_count;

   int checks = 0;
   int errors = 0;
   int cyc;
   logic [DATA_W:0] exp_q[$];   // {last, data}

   always #5 clk = ~clk;

   output_burst_buffer #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .burst_req  (burst_req),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .rd_miss    (rd_miss),
      .valid_count(valid_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic last, input logic [DATA_W-1:0] d);
      exp_q.push_back({last, d});
   endtask

   // Pops one expected word per accepted handshake; called at a negedge
   task automatic drain(input string tag, input int budget, output int cycles);
      logic [DATA_W:0] e;
      cycles = 0;
      while (exp_q.size() > 0 && cycles < budget) begin
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            chk({tag, ".data"}, 64'(out_data), 64'(e[DATA_W-1:0]));
            chk({tag, ".last"}, 64'(out_last), 64'(e[DATA_W]));
         end
         @(negedge clk);
         cycles++;
      end
      if (exp_q.size() > 0) begin
         chk({tag, ".timeout"}, 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_req = 1'b0; rd_addr = '0; burst_req = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.valid", 64'(out_valid), 64'd0);
      chk("rst.last",  64'(out_last),  64'd0);
      chk("rst.miss",  64'(rd_miss),   64'd0);
      chk("rst.busy",  64'(busy),      64'd0);
      chk("rst.count", 64'(valid_count), 64'd0);
      chk("rst.data",  64'(out_data),  64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single read of addr 3
      wr(4'd3, 32'hA5A5_0001);
      chk("single.count0", 64'(valid_count), 64'd1);
      rd_req = 1'b1; rd_addr = 4'd3;
      push(1'b1, 32'hA5A5_0001);
      @(negedge clk);
      rd_req = 1'b0;
      chk("single.valid", 64'(out_valid), 64'd1);
      chk("single.busy",  64'(busy), 64'd1);
      drain("single", 5, cyc);
      chk("single.done",  64'(out_valid), 64'd0);
      chk("single.idle",  64'(busy), 64'd0);
      chk("single.count", 64'(valid_count), 64'd1);

      // Read of a never-written entry
      rd_req = 1'b1; rd_addr = 4'd7;
      @(negedge clk);
      rd_req = 1'b0;
      chk("miss.pulse", 64'(rd_miss), 64'd1);
      chk("miss.valid", 64'(out_valid), 64'd0);
      chk("miss.busy",  64'(busy), 64'd0);
      @(negedge clk);
      chk("miss.end",   64'(rd_miss), 64'd0);

      // One-entry burst empties the buffer, then an empty burst misses
      burst_req = 1'b1;
      push(1'b1, 32'hA5A5_0001);
      @(negedge clk);
      burst_req = 1'b0;
      drain("burst1", 5, cyc);
      chk("burst1.count", 64'(valid_count), 64'd0);
      burst_req = 1'b1;
      @(negedge clk);
      burst_req = 1'b0;
      chk("empty.miss", 64'(rd_miss), 64'd1);
      chk("empty.busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("empty.end",  64'(rd_miss), 64'd0);

      // Three-entry back-to-back burst
      wr(4'd1, 32'h11);
      wr(4'd4, 32'h44);
      wr(4'd15, 32'hFF);
      burst_req = 1'b1;
      push(1'b0, 32'h11);
      push(1'b0, 32'h44);
      push(1'b1, 32'hFF);
      @(negedge clk);
      burst_req = 1'b0;
      chk("b3.latency", 64'(out_valid), 64'd1);
      drain("b3", 10, cyc);
      chk("b3.cycles", 64'(cyc), 64'd3);
      chk("b3.done",   64'(out_valid), 64'd0);
      chk("b3.count",  64'(valid_count), 64'd0);

      // Stalled burst with writes and ignored requests during the stall
      wr(4'd2, 32'h22);
      wr(4'd5, 32'h55);
      out_ready = 1'b0;
      burst_req = 1'b1;
      @(negedge clk);
      burst_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("stall.valid", 64'(out_valid), 64'd1);
         chk("stall.data",  64'(out_data), 64'h22);
         chk("stall.last",  64'(out_last), 64'd0);
         chk("stall.busy",  64'(busy), 64'd1);
         if (k >= 1) chk("stall.nomiss", 64'(rd_miss), 64'd0);
         rd_req    = (k == 0);
         burst_req = (k == 0);
         rd_addr   = 4'd7;
         wr_en     = (k >= 1);
         wr_addr   = (k == 1) ? 4'd5 : (k == 2) ? 4'd9 : 4'd2;
         wr_data   = (k == 1) ? 32'h99 : (k == 2) ? 32'h09 : 32'h2F;
         @(negedge clk);
      end
      rd_req = 1'b0; burst_req = 1'b0; wr_en = 1'b0;
      chk("stall.nomiss2", 64'(rd_miss), 64'd0);
      chk("stall.hold",    64'(out_data), 64'h22);
      chk("stall.valid2",  64'(out_valid), 64'd1);
      out_ready = 1'b1;
      push(1'b0, 32'h22);
      push(1'b1, 32'h99);
      drain("stall", 10, cyc);
      chk("stall.cycles", 64'(cyc), 64'd2);
      chk("stall.count",  64'(valid_count), 64'd1);
      chk("stall.idle",   64'(busy), 64'd0);

      // Write colliding with the handshake clear of the same address
      burst_req = 1'b1;
      @(negedge clk);
      burst_req = 1'b0;
      chk("coll.valid", 64'(out_valid), 64'd1);
      chk("coll.data",  64'(out_data), 64'h09);
      chk("coll.last",  64'(out_last), 64'd1);
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h90;
      @(negedge clk);
      wr_en = 1'b0;
      chk("coll.done",  64'(out_valid), 64'd0);
      chk("coll.count", 64'(valid_count), 64'd1);
      rd_req = 1'b1; rd_addr = 4'd9;
      push(1'b1, 32'h90);
      @(negedge clk);
      rd_req = 1'b0;
      drain("coll.rd", 5, cyc);

      // Simultaneous read and burst: read wins, burst dropped
      wr(4'd10, 32'hAA);
      rd_req = 1'b1; burst_req = 1'b1; rd_addr = 4'd9;
      push(1'b1, 32'h90);
      @(negedge clk);
      rd_req = 1'b0; burst_req = 1'b0;
      drain("rdwin", 5, cyc);
      chk("rdwin.idle",  64'(busy), 64'd0);
      chk("rdwin.valid", 64'(out_valid), 64'd0);
      chk("rdwin.count", 64'(valid_count), 64'd2);

      // Reset mid-burst aborts immediately
      out_ready = 1'b0;
      burst_req = 1'b1;
      @(negedge clk);
      burst_req = 1'b0;
      chk("abort.pre", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort.valid", 64'(out_valid), 64'd0);
      chk("abort.busy",  64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort.idle",  64'(busy), 64'd0);
      chk("abort.count", 64'(valid_count), 64'd0);
      chk("abort.data",  64'(out_data), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
